// File: rtl/mdu_issue_if.sv
// Pipeline-side bundle of the MDU issue controller: E/D opcodes and flush in,
// MDU start strobe plus busy/stall/violation status out.
interface mdu_issue_if;
  logic [3:0] E_MDUOp;
  logic [3:0] D_MDUOp;
  logic       flush;
  logic       start;
  logic [3:0] MDUOp;
  logic       busy;
  logic       stall;
  logic       viol;

  modport master (
    input  E_MDUOp, D_MDUOp, flush,
    output start, MDUOp, busy, stall, viol
  );

  modport slave (
    output E_MDUOp, D_MDUOp, flush,
    input  start, MDUOp, busy, stall, viol
  );
endinterface

// File: rtl/mdu_issue.sv
// E-stage issue and stall controller for the multiply/divide unit.
// Optional feature: define MDU_STALL_CNT_EN to add the saturating stall_cycles counter.
module mdu_issue #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_issue_if.master bus
`ifdef MDU_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       viol_q, viol_d;

  logic e_valid, e_mul, e_muldiv, d_valid;
  logic busy_w, issue_w, viol_case_w, stall_w;

  // Opcodes 9..15 are not MDU operations and behave exactly like 0.
  always_comb begin
    e_valid     = (bus.E_MDUOp >= 4'd1) && (bus.E_MDUOp <= 4'd8);
    e_muldiv    = (bus.E_MDUOp >= 4'd1) && (bus.E_MDUOp <= 4'd4);
    e_mul       = (bus.E_MDUOp == 4'd1) || (bus.E_MDUOp == 4'd2);
    d_valid     = (bus.D_MDUOp >= 4'd1) && (bus.D_MDUOp <= 4'd8);
    busy_w      = (state_q == BUSY);
    viol_case_w = !reset && e_valid && busy_w;
    issue_w     = !reset && e_valid && !bus.flush && !busy_w;
    stall_w     = !reset && d_valid && (busy_w || (issue_w && e_muldiv));
  end

  assign bus.start = issue_w;
  assign bus.MDUOp = issue_w ? bus.E_MDUOp : 4'd0;
  assign bus.busy  = busy_w;
  assign bus.stall = stall_w;
  assign bus.viol  = !reset && (viol_q || viol_case_w);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    viol_d  = viol_q || viol_case_w;
    case (state_q)
      IDLE: begin
        if (issue_w && e_mul) begin
          state_d = BUSY;
          cnt_d   = 4'(MUL_CYCLES);
        end else if (issue_w && e_muldiv) begin
          state_d = BUSY;
          cnt_d   = 4'(DIV_CYCLES);
        end
      end
      BUSY: begin
        // Flush never aborts a running operation; the countdown always completes.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      viol_q  <= viol_d;
    end
  end

`ifdef MDU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
